// File: rtl/noc_input_fifo.sv
// Per-port router input buffer: first-word fall-through FIFO exposing the head
// flit's destination address, registered status flags and sticky error flags.
module noc_input_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         push_i,
    output logic                         full_o,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [7:0]                   packet_addr_o,
    output logic                         packet_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push_acc;
    logic             pop_acc;

    // Next-state: pointers, occupancy and flags; status is decoded from the next count
    // so full/valid flops always mirror the registered count.
    always_comb begin
        push_acc    = push_i & ~full_q;
        pop_acc     = pop_i & valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push_i & full_q);
        underflow_d = underflow_q | (pop_i & ~valid_q);

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o         = mem_q[rd_ptr_q];
    assign packet_addr_o  = data_o[7:0];
    assign packet_valid_o = valid_q;
    assign full_o         = full_q;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_noc_input_fifo.sv
// Bench for noc_input_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_noc_input_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          push_i;
    logic          pop_i;
    logic          full_o;
    logic [DW-1:0] data_o;
    logic [7:0]    packet_addr_o;
    logic          packet_valid_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          underflow_o;

    noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .push_i         (push_i),
        .full_o         (full_o),
        .pop_i          (pop_i),
        .data_o         (data_o),
        .packet_addr_o  (packet_addr_o),
        .packet_valid_o (packet_valid_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    logic [DW-1:0] model_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of accepted flits with sticky error bits.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            int sz;
            sz = model_q.size();
            if (push_i && sz == DEPTH) m_ovf = 1'b1;
            if (pop_i && sz == 0)      m_unf = 1'b1;
            if (pop_i && sz != 0)      void'(model_q.pop_front());
            if (push_i && sz != DEPTH) model_q.push_back(data_i);
        end
    end

    // Compare all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("count", DW'(count_o), DW'(model_q.size()));
            chk("full", DW'(full_o), DW'(model_q.size() == DEPTH));
            chk("valid", DW'(packet_valid_o), DW'(model_q.size() != 0));
            chk("overflow", DW'(overflow_o), DW'(m_ovf));
            chk("underflow", DW'(underflow_o), DW'(m_unf));
            if (model_q.size() != 0) begin
                chk("data", data_o, model_q[0]);
                chk("addr", DW'(packet_addr_o), DW'(model_q[0][7:0]));
            end
        end
    end

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic step(input bit r, input bit pu, input logic [DW-1:0] d, input bit po);
        rst    = r;
        push_i = pu;
        data_i = d;
        pop_i  = po;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; push_i = 1'b0; pop_i = 1'b0; data_i = '0;
        @(negedge clk);
        step(1'b1, 1'b0, '0, 1'b0);
        idle();
        checking = 1'b1;
        chk("lit_reset_count", DW'(count_o), 0);
        chk("lit_reset_valid", DW'(packet_valid_o), 0);

        // Three consecutive pushes
        step(1'b0, 1'b1, 32'hA5A5_0012, 1'b0);
        chk("lit_cnt1", DW'(count_o), 1);
        chk("lit_addr12", DW'(packet_addr_o), 32'h12);
        step(1'b0, 1'b1, 32'hA5A5_0023, 1'b0);
        chk("lit_cnt2", DW'(count_o), 2);
        step(1'b0, 1'b1, 32'hA5A5_0034, 1'b0);
        chk("lit_cnt3", DW'(count_o), 3);
        chk("lit_not_full", DW'(full_o), 0);

        // Fill, overflow, drain in order
        step(1'b0, 1'b1, 32'hA5A5_0045, 1'b0);
        chk("lit_full", DW'(full_o), 1);
        step(1'b0, 1'b1, 32'hDEAD_00FF, 1'b0);
        chk("lit_ovf", DW'(overflow_o), 1);
        chk("lit_cnt4", DW'(count_o), 4);
        chk("lit_head0", data_o, 32'hA5A5_0012);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("lit_head1", data_o, 32'hA5A5_0023);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("lit_head2", data_o, 32'hA5A5_0034);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("lit_head3", data_o, 32'hA5A5_0045);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("lit_empty", DW'(packet_valid_o), 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0000_0100 + DW'(i), 1'b0);
        step(1'b0, 1'b1, 32'h0000_BEEF, 1'b1);
        chk("lit_fullpp_cnt", DW'(count_o), 3);
        chk("lit_fullpp_head", data_o, 32'h0000_0101);

        // Steady push+pop at count 2 across wrap
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, DW'(i), 1'b1);
        chk("lit_stream_cnt", DW'(count_o), 2);
        chk("lit_stream_addr", DW'(packet_addr_o), 32'h09);

        // Drain, pop empty, then pop+push on empty
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("lit_unf", DW'(underflow_o), 1);
        chk("lit_unf_cnt", DW'(count_o), 0);
        step(1'b0, 1'b1, 32'h0000_0044, 1'b1);
        chk("lit_44_valid", DW'(packet_valid_o), 1);
        chk("lit_44_addr", DW'(packet_addr_o), 32'h44);

        // Reset mid-operation with push asserted
        step(1'b0, 1'b1, 32'h0000_0066, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0077, 1'b0);
        chk("lit_pre_rst_cnt", DW'(count_o), 3);
        step(1'b1, 1'b1, 32'h0000_0088, 1'b0);
        chk("lit_rst_cnt", DW'(count_o), 0);
        chk("lit_rst_valid", DW'(packet_valid_o), 0);
        chk("lit_rst_ovf", DW'(overflow_o), 0);
        chk("lit_rst_unf", DW'(underflow_o), 0);
        step(1'b0, 1'b1, 32'h0000_0055, 1'b0);
        chk("lit_55_addr", DW'(packet_addr_o), 32'h55);
        idle();
        idle();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
